ram_req_ctrl: RTL and testbench
===============================

RAM_REQ_CTRL -- requirements
Module: ram_req_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8: RAM word-address width.
REQ-002 SHALL have parameter NUM_WORDS, default 256: number of 32-bit words in the attached RAM (NUM_WORDS <= 2**ADDR_WIDTH).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte base address, 4-byte aligned.
REQ-004 SHALL have parameter RSP_DEPTH, default 3: response FIFO entries, >= 2.
REQ-005 Ports (name  direction  width  meaning):
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_i  in  1  request valid
- gnt_o  out  1  request accepted this cycle when req_i && gnt_o
- addr_i  in  32  byte address
- we_i  in  1  1 = write, 0 = read
- be_i  in  4  byte enables, bit i = wdata_i[8i+7:8i]
- wdata_i  in  32  write data
- rvalid_o  out  1  response valid
- rready_i  in  1  response consumed when rvalid_o && rready_i
- rdata_o  out  32  read data; 0 for writes and errors
- err_o  out  1  response is an error
- ram_en_o  out  1  RAM enable
- ram_we_o  out  1  RAM write enable
- ram_addr_o  out  ADDR_WIDTH  RAM word address
- ram_be_o  out  4  RAM byte enables
- ram_wdata_o  out  32  RAM write data
- ram_rdata_i  in  32  RAM read data, valid the cycle after a ram_en_o cycle

Function
REQ-006 SHALL keep a pending stage (pend_v, pend_we, pend_err) and a RSP_DEPTH-entry in-order response FIFO of {rdata, err}.
REQ-007 SHALL drive gnt_o = rst_n && (fifo_count + pend_v < RSP_DEPTH), from registered state only; no combinational path from req_i or rready_i.
REQ-008 SHALL classify an accepted request as an error when addr_i[1:0] != 0, addr_i < BASE_ADDR, or addr_i >= BASE_ADDR + 4*NUM_WORDS.
REQ-009 SHALL, for a non-error accepted request, drive ram_en_o=1 combinationally in the acceptance cycle, with ram_we_o=we_i, ram_addr_o=(addr_i-BASE_ADDR)>>2 truncated to ADDR_WIDTH, ram_be_o=be_i, ram_wdata_o=wdata_i.
REQ-010 SHALL hold ram_en_o=0 and ram_we_o=0 in every other cycle, including error requests and rst_n low.
REQ-011 SHALL, at the acceptance edge, set pend_v=1, pend_we=we_i, pend_err=error flag; otherwise pend_v=0.
REQ-012 SHALL, when pend_v=1, push one entry at the next edge: rdata = ram_rdata_i for a non-error read, else 0; err = pend_err.
REQ-013 SHALL treat a write with be_i=4'b0000 as a normal write (RAM access, OK response).
REQ-014 SHALL drive rvalid_o = (fifo_count != 0), with rdata_o/err_o taken from the FIFO head.
REQ-015 SHALL allow push and pop at the same edge; count stays unchanged and ordering is preserved.
REQ-016 SHALL keep rvalid_o, rdata_o and err_o stable while rvalid_o && !rready_i.
REQ-017 Latency: the response for a request accepted at edge N SHALL be visible at the earliest after edge N+1 when the FIFO is empty (rvalid_o high in cycle N+2 counting the acceptance cycle as N).
REQ-018 SHALL sustain one accepted request per cycle with RSP_DEPTH=3 and rready_i held at 1.
REQ-019 SHALL implement the FIFO read and write pointers as wrap-around counters modulo RSP_DEPTH.

Reset
REQ-020 SHALL, while rst_n=0, clear pend_v, FIFO count and pointers, and hold gnt_o=0, rvalid_o=0, err_o=0, rdata_o=0, ram_en_o=0.
REQ-021 SHALL discard in-flight requests and queued responses on reset assertion; nothing is emitted for them after release.
REQ-022 SHALL accept requests from the first rising edge with rst_n=1.

Verification
REQ-023 Write 0xDEADBEEF at BASE+0x10 with be=4'hF, then read it back with rready=1 -> ram_addr_o=4, one OK write response with rdata 0, then a read response with rdata 0xDEADBEEF.
REQ-024 Write 0x11223344 with be=4'b0101 over a word holding 0 -> subsequent read returns 0x00220044.
REQ-025 Read at BASE+0x2 and at BASE+4*NUM_WORDS -> ram_en_o never asserted; two responses with err_o=1 and rdata_o=0, in order.
REQ-026 rready=0 with back-to-back reads -> exactly 3 grants, then gnt_o=0; raise rready -> 3 responses in issue order, then grants resume.
REQ-027 Continuous reads with rready=1 -> gnt_o=1 every cycle after the first.
REQ-028 Assert rst_n low with 2 queued responses and 1 pending -> rvalid_o=0 immediately; after release, no stale response appears.

Source files
------------

// File: rtl/ram_req_ctrl.sv
// rtl/ram_req_ctrl.sv - request/response front end for a single-port 32-bit RAM
//
// Accepts one request per cycle, drives the RAM in the acceptance cycle, and
// returns in-order responses through a small FIFO with valid/ready handshake.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_i/gnt_o                      request handshake
//   addr_i/we_i/be_i/wdata_i         request byte address, direction, byte enables, data
//   rvalid_o/rready_i                response handshake
//   rdata_o/err_o                    response data (0 for writes/errors), error flag
//   ram_en_o/ram_we_o/ram_addr_o     RAM control and word address
//   ram_be_o/ram_wdata_o/ram_rdata_i RAM byte enables, write data, read data (1-cycle latency)
module ram_req_ctrl #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned NUM_WORDS  = 256,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned RSP_DEPTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [31:0]           addr_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [31:0]           wdata_i,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic [31:0]           rdata_o,
  output logic                  err_o,
  output logic                  ram_en_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [3:0]            ram_be_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  // One bit wider than the address so BASE + size cannot wrap.
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'(NUM_WORDS) << 2);

  logic             pend_v;
  logic             pend_we;
  logic             pend_err;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic [31:0]      fifo_rdata [RSP_DEPTH];
  logic             fifo_err   [RSP_DEPTH];

  logic             req_err;
  logic             accept;
  logic             push;
  logic             pop;
  logic [CNT_W:0]   occupancy;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Occupancy counts the pending slot too, so a grant always has a FIFO
  // entry reserved for its response; depends on registered state only.
  assign occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(pend_v);
  assign gnt_o     = rst_n && (occupancy < (CNT_W + 1)'(RSP_DEPTH));

  assign req_err = (addr_i[1:0] != 2'b00) ||
                   (addr_i < BASE_ADDR) ||
                   ({1'b0, addr_i} >= END_ADDR);

  assign accept = req_i && gnt_o;

  assign ram_en_o    = accept && !req_err;
  assign ram_we_o    = ram_en_o && we_i;
  assign ram_addr_o  = ADDR_WIDTH'((addr_i - BASE_ADDR) >> 2);
  assign ram_be_o    = be_i;
  assign ram_wdata_o = wdata_i;

  assign push = pend_v;
  assign pop  = rvalid_o && rready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v     <= 1'b0;
      pend_we    <= 1'b0;
      pend_err   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      pend_v <= accept;
      if (accept) begin
        pend_we  <= we_i;
        pend_err <= req_err;
      end
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed while counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rdata[wr_ptr] <= (pend_we || pend_err) ? 32'h0 : ram_rdata_i;
      fifo_err[wr_ptr]   <= pend_err;
    end
  end

  assign rvalid_o = (fifo_count != '0);
  // Gated so stale storage never shows while empty or in reset.
  assign rdata_o  = rvalid_o ? fifo_rdata[rd_ptr] : 32'h0;
  assign err_o    = rvalid_o && fifo_err[rd_ptr];

endmodule

// File: tb/tb_ram_req_ctrl.sv
// tb/tb_ram_req_ctrl.sv - directed self-checking bench for ram_req_ctrl
module tb_ram_req_ctrl;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          NW   = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_i;
  logic        gnt_o;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic        rready_i;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        ram_en_o;
  logic        ram_we_o;
  logic [7:0]  ram_addr_o;
  logic [3:0]  ram_be_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i = 32'h0;

  int          total = 0;
  int          bad   = 0;
  logic [32:0] sb [$];
  logic [32:0] mon_e;
  logic [31:0] ram_mem [NW];

  ram_req_ctrl #(
    .ADDR_WIDTH(8), .NUM_WORDS(NW), .BASE_ADDR(BASE), .RSP_DEPTH(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
    .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o),
    .rready_i(rready_i), .rdata_o(rdata_o), .err_o(err_o), .ram_en_o(ram_en_o),
    .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_be_o(ram_be_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < NW; i++) ram_mem[i] = 32'h0;
  end

  // Attached RAM: byte-masked writes, registered reads.
  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o) begin
        for (int i = 0; i < 4; i++)
          if (ram_be_o[i]) ram_mem[ram_addr_o][8*i +: 8] <= ram_wdata_o[8*i +: 8];
      end else begin
        ram_rdata_i <= ram_mem[ram_addr_o];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: a pop happens at the next edge when valid && ready.
  always @(negedge clk) begin
    if (rst_n && rvalid_o && rready_i) begin
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_rsp observed=%h expected=none", rdata_o);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("rsp_rdata", rdata_o, mon_e[31:0]);
        chk("rsp_err", 32'(err_o), 32'(mon_e[32]));
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] b,
                       input logic [31:0] d, input logic [31:0] exp_rdata,
                       input logic exp_err, output int waits);
    bit ok;
    ok      = 1'b0;
    waits   = 0;
    req_i   = 1'b1;
    addr_i  = a;
    we_i    = w;
    be_i    = b;
    wdata_i = d;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (gnt_o) ok = 1'b1;
      else begin
        waits++;
        @(posedge clk); #1;
      end
    end
    if (!ok) chk("grant_timeout", 32'(ok), 32'd1);
    else begin
      chk("ram_en", 32'(ram_en_o), 32'(!exp_err));
      chk("ram_we", 32'(ram_we_o), 32'(w && !exp_err));
      sb.push_back({exp_err, exp_rdata});
      @(posedge clk); #1;
    end
    req_i = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && !rvalid_o) done = 1'b1;
    end
    chk("drain", 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int grants;
    rst_n = 1'b0; req_i = 1'b1; addr_i = BASE; we_i = 1'b0; be_i = 4'hF;
    wdata_i = 32'h0; rready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_rvalid", 32'(rvalid_o), 32'd0);
    chk("rst_ram_en", 32'(ram_en_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    req_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // write then read back
    issue(BASE + 32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0, w);
    chk("first_waits", 32'(w), 32'd0);
    chk("ram_addr", 32'(ram_addr_o), 32'd4);
    issue(BASE + 32'h10, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0, w);
    drain();

    // partial byte enables, then an empty-mask write
    issue(BASE + 32'h20, 1'b1, 4'hF,    32'h0,         32'h0, 1'b0, w);
    issue(BASE + 32'h20, 1'b1, 4'b0101, 32'h1122_3344, 32'h0, 1'b0, w);
    issue(BASE + 32'h20, 1'b0, 4'hF,    32'h0, 32'h0022_0044, 1'b0, w);
    issue(BASE + 32'h20, 1'b1, 4'h0,    32'hFFFF_FFFF, 32'h0, 1'b0, w);
    issue(BASE + 32'h20, 1'b0, 4'hF,    32'h0, 32'h0022_0044, 1'b0, w);
    drain();

    // error requests and ordering against a following good read
    issue(BASE + 32'h2,      1'b0, 4'hF, 32'h0, 32'h0, 1'b1, w);
    issue(BASE + 32'(4*NW),  1'b0, 4'hF, 32'h0, 32'h0, 1'b1, w);
    issue(BASE - 32'h4,      1'b1, 4'hF, 32'h5, 32'h0, 1'b1, w);
    issue(BASE + 32'h10,     1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0, w);
    drain();

    // latency and hold-while-stalled
    rready_i = 1'b0;
    issue(BASE + 32'h10, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0, w);
    @(negedge clk);
    chk("lat_n1_rvalid", 32'(rvalid_o), 32'd0);
    @(negedge clk);
    chk("lat_n2_rvalid", 32'(rvalid_o), 32'd1);
    @(negedge clk);
    chk("hold_rvalid", 32'(rvalid_o), 32'd1);
    chk("hold_rdata", rdata_o, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    rready_i = 1'b1;
    drain();

    // preload distinct words for ordering tests
    for (int i = 0; i < 5; i++)
      issue(BASE + 32'h40 + 32'(4*i), 1'b1, 4'hF, 32'hA000_0000 + 32'(i), 32'h0, 1'b0, w);
    drain();

    // backpressure: exactly RSP_DEPTH grants
    rready_i = 1'b0;
    grants = 0;
    req_i = 1'b1; we_i = 1'b0; be_i = 4'hF;
    for (int c = 0; c < 10; c++) begin
      addr_i = BASE + 32'h40 + 32'(4*grants);
      @(negedge clk);
      if (gnt_o) begin
        sb.push_back({1'b0, 32'hA000_0000 + 32'(grants)});
        grants++;
      end
      @(posedge clk); #1;
    end
    chk("bp_grants", 32'(grants), 32'd3);
    chk("bp_gnt_low", 32'(gnt_o), 32'd0);
    req_i = 1'b0;
    rready_i = 1'b1;
    drain();
    chk("bp_gnt_resume", 32'(gnt_o), 32'd1);

    // full throughput
    for (int i = 0; i < 8; i++) begin
      issue(BASE + 32'h40 + 32'(4*(i % 5)), 1'b0, 4'hF, 32'h0,
            32'hA000_0000 + 32'(i % 5), 1'b0, w);
      chk("tput_waits", 32'(w), 32'd0);
    end
    drain();

    // reset with 2 queued + 1 pending
    rready_i = 1'b0;
    issue(BASE + 32'h40, 1'b0, 4'hF, 32'h0, 32'hA000_0000, 1'b0, w);
    issue(BASE + 32'h44, 1'b0, 4'hF, 32'h0, 32'hA000_0001, 1'b0, w);
    issue(BASE + 32'h48, 1'b0, 4'hF, 32'h0, 32'hA000_0002, 1'b0, w);
    chk("pre_rst_rvalid", 32'(rvalid_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", 32'(rvalid_o), 32'd0);
    chk("mid_rst_gnt", 32'(gnt_o), 32'd0);
    sb.delete();
    rready_i = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(BASE + 32'h4C, 1'b0, 4'hF, 32'h0, 32'hA000_0003, 1'b0, w);
    chk("post_rst_waits", 32'(w), 32'd0);
    drain();
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_idle", 32'(rvalid_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
